// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key controller: scancode constants,
// the controller state encoding and small scancode helper functions.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_POP  = 1'b1
  } state_t;

  // True for either shift key scancode.
  function automatic logic is_shift(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

  // Lower-case ASCII letters map to upper case; everything else passes.
  function automatic logic [7:0] to_upper(input logic [7:0] ch);
    if (ch >= 8'h61 && ch <= 8'h7a)
      return ch - 8'h20;
    return ch;
  endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Bus between the PS/2 receiver FIFO / display path and the key controller.
// master: receiver + display side, slave: the key controller.
interface ps2_key_ctrl_if;
  logic [7:0] ps2_data;
  logic       ready;
  logic       overflow;
  logic       nextdata_n;
  logic [7:0] key_value;
  logic [7:0] ascii_value;
  logic       key_down;
  logic       new_key;
  logic [7:0] key_count;

  modport master (
    output ps2_data, ready, overflow,
    input  nextdata_n, key_value, ascii_value, key_down, new_key, key_count
  );

  modport slave (
    input  ps2_data, ready, overflow,
    output nextdata_n, key_value, ascii_value, key_down, new_key, key_count
  );
endinterface

// File: rtl/ps2_key_ctrl_rom.sv
// Combinational scancode (set 2) to ASCII lookup. Unmapped codes give 8'h00.
module rom (
  input  logic [7:0] i_key_value,
  output logic [7:0] o_ascii
);

  // Pure lookup table; no state.
  always_comb begin
    o_ascii = 8'h00;
    case (i_key_value)
      8'h1C: o_ascii = 8'h61; 8'h32: o_ascii = 8'h62; 8'h21: o_ascii = 8'h63;
      8'h23: o_ascii = 8'h64; 8'h24: o_ascii = 8'h65; 8'h2B: o_ascii = 8'h66;
      8'h34: o_ascii = 8'h67; 8'h33: o_ascii = 8'h68; 8'h43: o_ascii = 8'h69;
      8'h3B: o_ascii = 8'h6A; 8'h42: o_ascii = 8'h6B; 8'h4B: o_ascii = 8'h6C;
      8'h3A: o_ascii = 8'h6D; 8'h31: o_ascii = 8'h6E; 8'h44: o_ascii = 8'h6F;
      8'h4D: o_ascii = 8'h70; 8'h15: o_ascii = 8'h71; 8'h2D: o_ascii = 8'h72;
      8'h1B: o_ascii = 8'h73; 8'h2C: o_ascii = 8'h74; 8'h3C: o_ascii = 8'h75;
      8'h2A: o_ascii = 8'h76; 8'h1D: o_ascii = 8'h77; 8'h22: o_ascii = 8'h78;
      8'h35: o_ascii = 8'h79; 8'h1A: o_ascii = 8'h7A;
      // Digit row: the display counts from the leftmost key as '0'.
      8'h16: o_ascii = 8'h30; 8'h1E: o_ascii = 8'h31; 8'h26: o_ascii = 8'h32;
      8'h25: o_ascii = 8'h33; 8'h2E: o_ascii = 8'h34; 8'h36: o_ascii = 8'h35;
      8'h3D: o_ascii = 8'h36; 8'h3E: o_ascii = 8'h37; 8'h46: o_ascii = 8'h38;
      8'h45: o_ascii = 8'h39;
      8'h29: o_ascii = 8'h20; 8'h5A: o_ascii = 8'h0D;
      default: o_ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 key controller: pops bytes from the receiver FIFO, decodes
// make/break/extended/shift prefixes and presents the held key, its ASCII
// code and a press counter. Optional macro PS2_SHIFT_EN enables upper-case
// ASCII while a shift key is held.
module ps2_key_ctrl
  import ps2_pkg::*;
(
  input  logic         clk,
  input  logic         clrn,
  ps2_key_ctrl_if.slave bus
);

  state_t     r_state, w_state_next;
  logic [7:0] r_byte, w_byte_next;
  logic       r_nextdata_n, w_nextdata_n_next;
  logic       r_brk, w_brk_next;
  logic       r_ext, w_ext_next;
  logic [7:0] r_key_value, w_key_value_next;
  logic [7:0] r_ascii, w_ascii_next;
  logic       r_key_down, w_key_down_next;
  logic       r_new_key, w_new_key_next;
  logic [7:0] r_key_count, w_key_count_next;
  logic [7:0] w_rom_ascii;
  logic [7:0] w_ascii_shown;
`ifdef PS2_SHIFT_EN
  logic       r_shift, w_shift_next;
`endif

  rom u_rom (
    .i_key_value (r_byte),
    .o_ascii     (w_rom_ascii)
  );

`ifdef PS2_SHIFT_EN
  // Upper-case letters while a shift key is held at make time.
  assign w_ascii_shown = r_shift ? to_upper(w_rom_ascii) : w_rom_ascii;
`else
  assign w_ascii_shown = w_rom_ascii;
`endif

  // Next-state and decode logic for the pop/classify sequence.
  always_comb begin
    w_state_next      = r_state;
    w_byte_next       = r_byte;
    w_nextdata_n_next = 1'b1;
    w_brk_next        = r_brk;
    w_ext_next        = r_ext;
    w_key_value_next  = r_key_value;
    w_ascii_next      = r_ascii;
    w_key_down_next   = r_key_down;
    w_new_key_next    = 1'b0;
    w_key_count_next  = r_key_count;
`ifdef PS2_SHIFT_EN
    w_shift_next      = r_shift;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.overflow) begin
          // Stream lost sync: drop any half-seen prefix and the held key.
          w_brk_next      = 1'b0;
          w_ext_next      = 1'b0;
          w_key_down_next = 1'b0;
`ifdef PS2_SHIFT_EN
          w_shift_next    = 1'b0;
`endif
        end else if (bus.ready) begin
          w_byte_next       = bus.ps2_data;
          w_nextdata_n_next = 1'b0;
          w_state_next      = S_POP;
        end
      end
      S_POP: begin
        w_state_next = S_IDLE;
        if (r_byte == SC_BREAK) begin
          w_brk_next = 1'b1;
        end else if (r_byte == SC_EXT) begin
          w_ext_next = 1'b1;
        end else if (r_ext) begin
          // Extended keys are not shown; swallow make or break alike.
          w_ext_next = 1'b0;
          w_brk_next = 1'b0;
        end else if (r_brk) begin
`ifdef PS2_SHIFT_EN
          if (is_shift(r_byte))
            w_shift_next = 1'b0;
`endif
          if (r_byte == r_key_value)
            w_key_down_next = 1'b0;
          w_brk_next = 1'b0;
        end else if (is_shift(r_byte)) begin
`ifdef PS2_SHIFT_EN
          w_shift_next = 1'b1;
`endif
        end else if (!(r_byte == r_key_value && r_key_down)) begin
          // New press (typematic repeats of the held key fall through).
          w_key_value_next = r_byte;
          w_ascii_next     = w_ascii_shown;
          w_key_down_next  = 1'b1;
          w_key_count_next = r_key_count + 8'd1;
          w_new_key_next   = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state      <= S_IDLE;
      r_byte       <= 8'h00;
      r_nextdata_n <= 1'b1;
      r_brk        <= 1'b0;
      r_ext        <= 1'b0;
      r_key_value  <= 8'h00;
      r_ascii      <= 8'h00;
      r_key_down   <= 1'b0;
      r_new_key    <= 1'b0;
      r_key_count  <= 8'h00;
    end else begin
      r_state      <= w_state_next;
      r_byte       <= w_byte_next;
      r_nextdata_n <= w_nextdata_n_next;
      r_brk        <= w_brk_next;
      r_ext        <= w_ext_next;
      r_key_value  <= w_key_value_next;
      r_ascii      <= w_ascii_next;
      r_key_down   <= w_key_down_next;
      r_new_key    <= w_new_key_next;
      r_key_count  <= w_key_count_next;
    end
  end

`ifdef PS2_SHIFT_EN
  // Shift-held flag, kept apart so the default build carries no shift state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      r_shift <= 1'b0;
    else
      r_shift <= w_shift_next;
  end
`endif

  assign bus.nextdata_n  = r_nextdata_n;
  assign bus.key_value   = r_key_value;
  assign bus.ascii_value = r_ascii;
  assign bus.key_down    = r_key_down;
  assign bus.new_key     = r_new_key;
  assign bus.key_count   = r_key_count;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: directed streams from the test list
// plus a randomized byte stream scored against a behavioural key model.
module tb_ps2_key_ctrl;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  ps2_key_ctrl_if bus ();

  ps2_key_ctrl dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int nd_pulses = 0;
  int nk_pulses = 0;

  // Behavioural model of what a keyboard user sees.
  logic [7:0] tab [0:255];
  logic [7:0] m_key, m_ascii, m_count;
  bit         m_down, m_brk, m_ext, m_shift;

  // Pulse counters for the pop strobe and press pulse.
  always @(negedge clk) begin
    if (bus.nextdata_n === 1'b0) nd_pulses++;
    if (bus.new_key === 1'b1) nk_pulses++;
  end

  task automatic init_tab();
    logic [7:0] codes [0:37];
    string chars;
    for (int i = 0; i < 256; i++) tab[i] = 8'h00;
    codes = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
              8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
              8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A,
              8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45,
              8'h29,8'h5A};
    chars = "abcdefghijklmnopqrstuvwxyz0123456789 ";
    for (int i = 0; i < 37; i++) tab[codes[i]] = chars[i];
    tab[codes[37]] = 8'h0D;
  endtask

  task automatic model_reset();
    m_key = 0; m_ascii = 0; m_count = 0;
    m_down = 0; m_brk = 0; m_ext = 0; m_shift = 0;
  endtask

  // Apply one byte to the model; reports whether it is a counted press.
  task automatic model_byte(input logic [7:0] b, output bit counted);
    bit is_sh;
    logic [7:0] a;
    counted = 0;
    is_sh = (b == 8'h12) || (b == 8'h59);
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_ext) begin m_ext = 0; m_brk = 0; end
    else if (m_brk) begin
      if (is_sh) m_shift = 0;
      if (b == m_key) m_down = 0;
      m_brk = 0;
    end else if (is_sh) m_shift = 1;
    else if (!(b == m_key && m_down)) begin
      a = tab[b];
`ifdef PS2_SHIFT_EN
      if (m_shift && a >= "a" && a <= "z") a = a - 8'd32;
`endif
      m_key = b; m_ascii = a; m_down = 1; m_count = m_count + 8'd1;
      counted = 1;
    end
  endtask

  task automatic model_overflow();
    m_brk = 0; m_ext = 0; m_shift = 0; m_down = 0;
  endtask

  task automatic do_reset();
    bus.ready = 0; bus.overflow = 0; bus.ps2_data = 8'h00;
    clrn = 0;
    repeat (2) @(negedge clk);
    clrn = 1;
    @(negedge clk);
    model_reset();
  endtask

  // Offer one byte at a negedge; checks the pop strobe timing and press pulse.
  task automatic send_byte(input logic [7:0] b);
    bit counted;
    bus.ps2_data = b; bus.ready = 1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.nextdata_n !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_low byte=%02h nextdata_n=%b required 0", b, bus.nextdata_n);
    end
    @(negedge clk);
    bus.ready = 0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.nextdata_n !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_high byte=%02h nextdata_n=%b required 1", b, bus.nextdata_n);
    end
    model_byte(b, counted);
    n_checks++;
    if (bus.new_key !== counted) begin
      n_fail++;
      $display("FAIL new_key byte=%02h got=%b required %b", b, bus.new_key, counted);
    end
    @(negedge clk);
    $display("byte %02h -> key=%02h ascii=%02h down=%b count=%0d", b,
             bus.key_value, bus.ascii_value, bus.key_down, bus.key_count);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.nextdata_n, bus.key_value, bus.ascii_value, bus.key_down, bus.new_key, bus.key_count}
        !== {1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset nd=%b key=%02h ascii=%02h down=%b new=%b cnt=%02h required 1/00/00/0/0/00",
               bus.nextdata_n, bus.key_value, bus.ascii_value, bus.key_down, bus.new_key, bus.key_count);
    end
  endtask

  task automatic test_single_press();
    int nd0, nk0;
    do_reset();
    nd0 = nd_pulses; nk0 = nk_pulses;
    send_byte(8'h1C);
    n_checks++;
    if (bus.key_down !== 1'b1) begin n_fail++; $display("FAIL single_down got=%b required 1", bus.key_down); end
    send_byte(8'hF0);
    send_byte(8'h1C);
    n_checks++;
    if ({bus.key_value, bus.ascii_value, bus.key_count, bus.key_down} !== {8'h1C, 8'h61, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_press key=%02h ascii=%02h cnt=%0d down=%b required 1c/61/1/0",
               bus.key_value, bus.ascii_value, bus.key_count, bus.key_down);
    end
    n_checks++;
    if (nd_pulses - nd0 != 3 || nk_pulses - nk0 != 1) begin
      n_fail++;
      $display("FAIL single_pulses pops=%0d presses=%0d required 3/1", nd_pulses - nd0, nk_pulses - nk0);
    end
  endtask

  task automatic test_typematic();
    int nk0;
    do_reset();
    nk0 = nk_pulses;
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    n_checks++;
    if (bus.key_count !== 8'd1 || nk_pulses - nk0 != 1) begin
      n_fail++;
      $display("FAIL typematic cnt=%0d presses=%0d required 1/1", bus.key_count, nk_pulses - nk0);
    end
  endtask

  task automatic test_shift();
    logic [7:0] exp_a;
`ifdef PS2_SHIFT_EN
    exp_a = 8'h41;
`else
    exp_a = 8'h61;
`endif
    do_reset();
    send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0);
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
    n_checks++;
    if (bus.ascii_value !== exp_a || bus.key_count !== 8'd1 || bus.key_value !== 8'h1C) begin
      n_fail++;
      $display("FAIL shift ascii=%02h cnt=%0d key=%02h required %02h/1/1c",
               bus.ascii_value, bus.key_count, bus.key_value, exp_a);
    end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    n_checks++;
    if (bus.key_count !== 8'd0) begin
      n_fail++; $display("FAIL ext_ignored cnt=%0d required 0", bus.key_count);
    end
    send_byte(8'h16);
    n_checks++;
    if ({bus.key_value, bus.ascii_value, bus.key_count} !== {8'h16, 8'h30, 8'd1}) begin
      n_fail++;
      $display("FAIL extended key=%02h ascii=%02h cnt=%0d required 16/30/1",
               bus.key_value, bus.ascii_value, bus.key_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h1C);
    send_byte(8'hF0);
    bus.overflow = 1;
    @(negedge clk);
    bus.overflow = 0;
    model_overflow();
    n_checks++;
    if (bus.key_down !== 1'b0) begin
      n_fail++; $display("FAIL overflow_down got=%b required 0", bus.key_down);
    end
    send_byte(8'h1C);
    n_checks++;
    if (bus.key_down !== 1'b1 || bus.key_count !== 8'd2) begin
      n_fail++;
      $display("FAIL overflow_make down=%b cnt=%0d required 1/2", bus.key_down, bus.key_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) send_byte((i % 2 == 0) ? 8'h1C : 8'h32);
    n_checks++;
    if (bus.key_count !== 8'd255) begin
      n_fail++; $display("FAIL wrap_255 cnt=%0d required 255", bus.key_count);
    end
    send_byte(8'h21);
    n_checks++;
    if (bus.key_count !== 8'd0 || bus.ascii_value !== 8'h63) begin
      n_fail++;
      $display("FAIL wrap_0 cnt=%0d ascii=%02h required 0/63", bus.key_count, bus.ascii_value);
    end
  endtask

  task automatic test_reset_in_pop();
    do_reset();
    send_byte(8'h1C);
    bus.ps2_data = 8'hF0; bus.ready = 1;
    @(posedge clk); #1;
    clrn = 0;
    #1;
    n_checks++;
    if ({bus.nextdata_n, bus.key_value, bus.ascii_value, bus.key_down, bus.new_key, bus.key_count}
        !== {1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_in_pop nd=%b key=%02h ascii=%02h down=%b new=%b cnt=%02h required 1/00/00/0/0/00",
               bus.nextdata_n, bus.key_value, bus.ascii_value, bus.key_down, bus.new_key, bus.key_count);
    end
    bus.ready = 0;
    @(negedge clk);
    clrn = 1;
    @(negedge clk);
    model_reset();
    send_byte(8'h1C);
    n_checks++;
    if (bus.key_count !== 8'd1 || bus.key_down !== 1'b1) begin
      n_fail++;
      $display("FAIL prefix_lost cnt=%0d down=%b required 1/1", bus.key_count, bus.key_down);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [0:13];
    logic [7:0] b;
    pool = '{8'hF0, 8'hF0, 8'hE0, 8'h12, 8'h59, 8'h1C, 8'h1C, 8'h32,
             8'h21, 8'h16, 8'h45, 8'h5A, 8'h77, 8'h1A};
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        bus.overflow = 1;
        @(negedge clk);
        bus.overflow = 0;
        model_overflow();
      end
      b = pool[$urandom_range(0, 13)];
      send_byte(b);
      n_checks++;
      if ({bus.key_value, bus.ascii_value, bus.key_down, bus.key_count} !== {m_key, m_ascii, m_down, m_count}) begin
        n_fail++;
        $display("FAIL random[%0d] byte=%02h key=%02h ascii=%02h down=%b cnt=%0d required %02h/%02h/%b/%0d",
                 i, b, bus.key_value, bus.ascii_value, bus.key_down, bus.key_count,
                 m_key, m_ascii, m_down, m_count);
      end
    end
  endtask

  initial begin
    init_tab();
    model_reset();
    test_reset();
    test_single_press();
    test_typematic();
    test_shift();
    test_extended();
    test_overflow();
    test_reset_in_pop();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Sequences the byte stream from the PS/2 receiver into key events for the display path. It pops scancode bytes with a ready/nextdata_n handshake and tracks make, break, extended and shift prefixes. It holds the current key and its ASCII code for the seven-segment display and counts distinct key presses. It sits between the PS/2 receiver and the display/seg driver, and owns the single scancode-to-ASCII lookup instance.

## Interface
- No parameters.
- clk  in  1  system clock; all state on rising edge.
- clrn  in  1  asynchronous active-low reset.
- ps2_data  in  8  head byte of the receiver FIFO.
- ready  in  1  receiver FIFO non-empty; ps2_data valid.
- overflow  in  1  receiver FIFO overflowed; stream is desynchronised.
- nextdata_n  out  1  active-low pop strobe, exactly one cycle per consumed byte.
- key_value  out  8  scancode of the currently/last held key.
- ascii_value  out  8  ASCII of key_value, registered at make time.
- key_down  out  1  a counted key is currently held.
- new_key  out  1  one-cycle pulse on each counted press.
- key_count  out  8  number of counted presses, binary, wraps 255→0.

## Operation
- States: S_IDLE, S_POP.
- S_IDLE
  - If overflow=1: clear brk_flag, ext_flag, shift_held and key_down; stay in S_IDLE. Overflow has priority over ready.
  - Else if ready=1: latch ps2_data into byte_r, drive nextdata_n=0, go to S_POP.
- S_POP: nextdata_n=1, classify byte_r, return to S_IDLE.
  - 8'hF0: set brk_flag.
  - 8'hE0: set ext_flag.
  - Otherwise, with ext_flag=1: discard the byte (extended make or break) and clear both flags.
  - Otherwise, with brk_flag=1 (break):
    - If byte_r is 8'h12 or 8'h59, clear shift_held.
    - If byte_r==key_value, clear key_down.
    - Clear brk_flag.
  - Otherwise (make):
    - 8'h12/8'h59: set shift_held. Not counted, key_value unchanged.
    - byte_r==key_value with key_down=1: typematic repeat; no change.
    - Anything else: key_value←byte_r, ascii_value←lookup(byte_r), key_down←1, key_count←key_count+1, new_key←1 for one cycle.
- A break for a key other than key_value changes nothing except shift state.
- Unmapped scancodes are still counted; the lookup returns 8'h00 for them.
- Reset values: nextdata_n=1, key_value=0, ascii_value=0, key_down=0, new_key=0, key_count=0, all flags 0, state S_IDLE.

## Timing
- Each byte takes 2 cycles: latch+pop in cycle N, decode in cycle N+1. A back-to-back ready byte is latched at N+2.
- nextdata_n is low for exactly cycle N+1, i.e. the cycle after ready is sampled.
- key_value, ascii_value, key_count and new_key update at the edge ending S_POP. new_key is high for the following cycle only.
- Sampling ps2_data while nextdata_n=1 is legal only in S_IDLE. The receiver must hold the head byte until the pop.
- clrn asserted mid-sequence (including in S_POP or between F0 and its code) returns every register to its reset value immediately. A half-received prefix is lost.

## Configuration
- PS2_SHIFT_EN defined: when shift_held=1 at make time and the lookup result is 8'h61–8'h7a, ascii_value is the result minus 8'h20 (upper case). Other codes pass unchanged.
- Undefined: shift scancodes are still swallowed (never counted, never shown), shift_held is not implemented, and ascii_value is always the raw lookup result.

## Structure
- Shared package ps2_pkg:
  - Scancode constants: SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59.
  - State encoding.
- One sub-module: the existing combinational scancode→ASCII lookup `rom`, instanced once with key_value input driven from byte_r in S_POP.

## Test plan
- Stream 1C, F0, 1C → one press: key_value=8'h1C, ascii_value=8'h61, key_count=1, one new_key pulse; key_down 1 then 0. Exactly 3 nextdata_n pulses.
- Stream 1C, 1C, 1C, F0, 1C (typematic) → key_count=1, single new_key pulse.
- Stream 12, 1C, F0, 1C, F0, 12 → ascii_value=8'h41 with PS2_SHIFT_EN, 8'h61 without; key_count=1 in both builds.
- Stream E0, 75, E0, F0, 75, then 16 → extended key ignored; key_value=8'h16, ascii_value=8'h30, key_count=1.
- Stream F0 then overflow=1 for 1 cycle, then 1C → flags cleared, 1C counted as a make, key_down=1.
- Preload key_count=255 via 255 presses, press again → key_count=0. Assert clrn low during S_POP → all outputs at reset values next cycle.
